// File: rtl/ethernet_encapsulation_if.sv
// Client-side bus of the GMII transmit framer: frame request, payload stream and GMII pins.
// Payload handshake: a byte moves on each rising clk edge where s_valid && s_ready; s_data must be stable while s_valid is high.
interface ethernet_encapsulation_if;
    logic        tx_start;
    logic [15:0] tx_len;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  gmii_data_out;
    logic        gmii_tx_en;
    logic        gmii_tx_er;
    logic        busy;
    logic        len_err;

    modport master (
        output tx_start, tx_len, s_data, s_valid,
        input  s_ready, gmii_data_out, gmii_tx_en, gmii_tx_er, busy, len_err
    );

    modport slave (
        input  tx_start, tx_len, s_data, s_valid,
        output s_ready, gmii_data_out, gmii_tx_en, gmii_tx_er, busy, len_err
    );
endinterface

// File: rtl/ethernet_encapsulation.sv
// GMII transmit framer: preamble, SFD, MAC header, length, payload, zero pad and CRC-32 FCS,
// followed by the inter-frame gap. All GMII outputs are registered; s_ready is decoded from state.
module ethernet_encapsulation #(
    parameter logic [47:0] destination_mac_addr = 48'h023528fbdd66,
    parameter logic [47:0] source_mac_addr      = 48'h072227acdb65,
    parameter int          MIN_PAYLOAD          = 46,
    parameter int          MAX_PAYLOAD          = 1500,
    parameter int          IFG_BYTES            = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    ethernet_encapsulation_if.slave  bus,
    output logic [3:0]               o_state
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_PREAMBLE = 4'd1,
        S_SFD      = 4'd2,
        S_DEST_MAC = 4'd3,
        S_SRC_MAC  = 4'd4,
        S_LEN      = 4'd5,
        S_PAYLOAD  = 4'd6,
        S_PAD      = 4'd7,
        S_FCS      = 4'd8,
        S_IFG      = 4'd9
    } state_t;

    localparam logic [15:0] LP_MIN      = 16'(MIN_PAYLOAD);
    localparam logic [15:0] LP_MAX      = 16'(MAX_PAYLOAD);
    // The IDLE cycle that samples the next tx_start is the last gap byte, so IFG state lasts one less.
    localparam logic [10:0] LP_IFG_LAST = 11'(IFG_BYTES - 2);
    localparam logic [31:0] LP_POLY     = 32'hEDB88320;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ LP_POLY) : (r >> 1);
        end
        return r;
    endfunction

    state_t      r_state;
    logic [10:0] r_cnt;
    logic [15:0] r_len;
    logic [31:0] r_crc;
    logic [7:0]  r_data;
    logic        r_en;
    logic        r_er;
    logic        r_busy;
    logic        r_len_err;

    state_t      w_state_next;
    logic [10:0] w_cnt_next;
    logic [15:0] w_len_next;
    logic [31:0] w_crc_next;
    logic [7:0]  w_data;
    logic        w_en;
    logic        w_er;
    logic        w_busy;
    logic        w_len_err;
    logic        w_crc_upd;
    logic        w_crc_init;
    logic        w_len_ok;
    logic        w_pay_last;
    logic        w_pad_last;
    logic [31:0] w_fcs;

    assign w_len_ok   = (bus.tx_len != 16'd0) && (bus.tx_len <= LP_MAX);
    assign w_pay_last = ({5'd0, r_cnt} == (r_len - 16'd1));
    assign w_pad_last = ({5'd0, r_cnt} == (LP_MIN - r_len - 16'd1));
    assign w_fcs      = ~r_crc;

    always_comb begin
        w_state_next = r_state;
        w_len_next   = r_len;
        w_data       = 8'h00;
        w_en         = 1'b0;
        w_er         = 1'b0;
        w_busy       = r_busy;
        w_len_err    = 1'b0;
        w_crc_upd    = 1'b0;
        w_crc_init   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.tx_start) begin
                    if (w_len_ok) begin
                        w_state_next = S_PREAMBLE;
                        w_len_next   = bus.tx_len;
                        w_busy       = 1'b1;
                        w_crc_init   = 1'b1;
                    end else begin
                        w_len_err = 1'b1;
                    end
                end
            end
            S_PREAMBLE: begin
                w_data = 8'h55;
                w_en   = 1'b1;
                if (r_cnt == 11'd6) w_state_next = S_SFD;
            end
            S_SFD: begin
                w_data       = 8'hD5;
                w_en         = 1'b1;
                w_state_next = S_DEST_MAC;
            end
            S_DEST_MAC: begin
                w_data    = destination_mac_addr[(6'd40 - {r_cnt[2:0], 3'b000}) +: 8];
                w_en      = 1'b1;
                w_crc_upd = 1'b1;
                if (r_cnt == 11'd5) w_state_next = S_SRC_MAC;
            end
            S_SRC_MAC: begin
                w_data    = source_mac_addr[(6'd40 - {r_cnt[2:0], 3'b000}) +: 8];
                w_en      = 1'b1;
                w_crc_upd = 1'b1;
                if (r_cnt == 11'd5) w_state_next = S_LEN;
            end
            S_LEN: begin
                w_data    = r_cnt[0] ? r_len[7:0] : r_len[15:8];
                w_en      = 1'b1;
                w_crc_upd = 1'b1;
                if (r_cnt == 11'd1) w_state_next = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                w_en = 1'b1;
                if (bus.s_valid) begin
                    w_data    = bus.s_data;
                    w_crc_upd = 1'b1;
                    if (w_pay_last) w_state_next = (r_len < LP_MIN) ? S_PAD : S_FCS;
                end else begin
                    // Underrun: flag the frame as errored and abandon it without an FCS.
                    w_er         = 1'b1;
                    w_state_next = S_IFG;
                end
            end
            S_PAD: begin
                w_en      = 1'b1;
                w_crc_upd = 1'b1;
                if (w_pad_last) w_state_next = S_FCS;
            end
            S_FCS: begin
                w_data = w_fcs[{r_cnt[1:0], 3'b000} +: 8];
                w_en   = 1'b1;
                if (r_cnt == 11'd3) w_state_next = S_IFG;
            end
            S_IFG: begin
                if (r_cnt == LP_IFG_LAST) begin
                    w_state_next = S_IDLE;
                    w_busy       = 1'b0;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_busy       = 1'b0;
            end
        endcase

        if (w_crc_init)     w_crc_next = 32'hFFFFFFFF;
        else if (w_crc_upd) w_crc_next = crc_byte(r_crc, w_data);
        else                w_crc_next = r_crc;

        if ((w_state_next != r_state) || (r_state == S_IDLE)) w_cnt_next = 11'd0;
        else                                                  w_cnt_next = r_cnt + 11'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 11'd0;
            r_len     <= 16'd0;
            r_crc     <= 32'hFFFFFFFF;
            r_data    <= 8'h00;
            r_en      <= 1'b0;
            r_er      <= 1'b0;
            r_busy    <= 1'b0;
            r_len_err <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_len     <= w_len_next;
            r_crc     <= w_crc_next;
            r_data    <= w_data;
            r_en      <= w_en;
            r_er      <= w_er;
            r_busy    <= w_busy;
            r_len_err <= w_len_err;
        end
    end

    assign bus.s_ready       = (r_state == S_PAYLOAD);
    assign bus.gmii_data_out = r_data;
    assign bus.gmii_tx_en    = r_en;
    assign bus.gmii_tx_er    = r_er;
    assign bus.busy          = r_busy;
    assign bus.len_err       = r_len_err;
    assign o_state           = r_state;

endmodule

// File: tb/tb_ethernet_encapsulation.sv
// Directed bench for the GMII transmit framer: records every output cycle, then checks
// frame layout, padding, FCS, underrun abort, length rejection and back-to-back spacing.
module tb_ethernet_encapsulation;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] o_state;

    ethernet_encapsulation_if bus();

    ethernet_encapsulation dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .o_state (o_state)
    );

    always #5 clk = ~clk;

    localparam logic [47:0] DEST = 48'h023528fbdd66;
    localparam logic [47:0] SRC  = 48'h072227acdb65;

    logic [7:0] pay [0:1599];
    int         feed_idx;
    int         feed_base;
    int         feed_lim;
    int         drop_at;
    int         n_fire;
    int         n_checks = 0;
    int         n_fail   = 0;

    logic       en_h[$];
    logic       er_h[$];
    logic       busy_h[$];
    logic       lerr_h[$];
    logic [7:0] d_h[$];
    logic [7:0] exp_q[$];
    int         fr_s[$];
    int         fr_e[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_add(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] != b[i]) r = {1'b0, r[31:1]} ^ 32'hEDB88320;
            else              r = {1'b0, r[31:1]};
        end
        return r;
    endfunction

    function automatic logic [7:0] getd(input int i);
        if (i >= 0 && i < d_h.size()) return d_h[i];
        return 8'hxx;
    endfunction

    task automatic start_hist();
        en_h.delete(); er_h.delete(); busy_h.delete(); lerr_h.delete(); d_h.delete();
        feed_idx = 0;
        n_fire   = 0;
    endtask

    // One clock: present payload, let the edge happen, record outputs 1 ns later.
    task automatic cyc();
        logic fire;
        bus.s_valid = (feed_idx < feed_lim) && (feed_idx < drop_at);
        bus.s_data  = pay[(feed_base + feed_idx) % 1600];
        fire        = bus.s_valid && bus.s_ready;
        @(posedge clk);
        #1;
        if (fire) begin
            feed_idx++;
            n_fire++;
        end
        en_h.push_back(bus.gmii_tx_en);
        er_h.push_back(bus.gmii_tx_er);
        busy_h.push_back(bus.busy);
        lerr_h.push_back(bus.len_err);
        d_h.push_back(bus.gmii_data_out);
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic find_frames();
        fr_s.delete();
        fr_e.delete();
        for (int i = 0; i < en_h.size(); i++) begin
            if (en_h[i] && (i == 0 || !en_h[i-1])) fr_s.push_back(i);
            if (en_h[i] && (i == en_h.size() - 1 || !en_h[i+1])) fr_e.push_back(i);
        end
    endtask

    function automatic int count_q(input int sel, input int lo, input int hi);
        int n;
        n = 0;
        for (int i = lo; i <= hi; i++) begin
            if (i >= 0 && i < en_h.size()) begin
                if (sel == 0 && en_h[i])   n++;
                if (sel == 1 && er_h[i])   n++;
                if (sel == 2 && lerr_h[i]) n++;
            end
        end
        return n;
    endfunction

    task automatic build_exp(input int len, input int base);
        logic [15:0] l16;
        logic [47:0] mac;
        logic [31:0] crc;
        l16 = 16'(len);
        exp_q.delete();
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        mac = DEST;
        for (int k = 0; k < 6; k++) exp_q.push_back(mac[47 - 8*k -: 8]);
        mac = SRC;
        for (int k = 0; k < 6; k++) exp_q.push_back(mac[47 - 8*k -: 8]);
        exp_q.push_back(l16[15:8]);
        exp_q.push_back(l16[7:0]);
        for (int i = 0; i < len; i++) exp_q.push_back(pay[base + i]);
        for (int i = len; i < 46; i++) exp_q.push_back(8'h00);
        crc = 32'hFFFFFFFF;
        for (int i = 8; i < exp_q.size(); i++) crc = crc_add(crc, exp_q[i]);
        crc = ~crc;
        exp_q.push_back(crc[7:0]);
        exp_q.push_back(crc[15:8]);
        exp_q.push_back(crc[23:16]);
        exp_q.push_back(crc[31:24]);
    endtask

    task automatic check_frame(input string tag, input int fi, input int len, input int base);
        int s, n, nbad, first, sz;
        logic [31:0] fcs_obs, fcs_exp;
        if (fr_s.size() <= fi) return;
        build_exp(len, base);
        sz = exp_q.size();
        s  = fr_s[fi];
        n  = fr_e[fi] - s + 1;
        check({tag, " tx_en cycles"}, 32'(n), 32'(sz));
        check({tag, " length field"}, 32'({getd(s + 20), getd(s + 21)}), 32'(len));
        nbad  = 0;
        first = -1;
        for (int i = 0; i < sz; i++) begin
            if (getd(s + i) !== exp_q[i]) begin
                nbad++;
                if (first < 0) first = i;
            end
        end
        check($sformatf("%s frame bytes (first bad index %0d)", tag, first), 32'(nbad), 32'd0);
        fcs_obs = {getd(s + sz - 1), getd(s + sz - 2), getd(s + sz - 3), getd(s + sz - 4)};
        fcs_exp = {exp_q[sz-1], exp_q[sz-2], exp_q[sz-3], exp_q[sz-4]};
        check({tag, " FCS"}, fcs_obs, fcs_exp);
    endtask

    initial begin
        int er_idx;
        int nz;

        for (int i = 0; i < 1600; i++) pay[i] = 8'(i);
        bus.tx_start = 1'b0;
        bus.tx_len   = 16'd0;
        bus.s_data   = 8'h00;
        bus.s_valid  = 1'b0;
        feed_idx  = 0;
        feed_base = 0;
        feed_lim  = 0;
        drop_at   = 1 << 30;
        n_fire    = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset tx_en",   32'(bus.gmii_tx_en),    32'd0);
        check("reset tx_er",   32'(bus.gmii_tx_er),    32'd0);
        check("reset data",    32'(bus.gmii_data_out), 32'd0);
        check("reset busy",    32'(bus.busy),          32'd0);
        check("reset len_err", 32'(bus.len_err),       32'd0);
        check("reset s_ready", 32'(bus.s_ready),       32'd0);
        check("reset state",   32'(o_state),           32'd0);
        rst = 1'b1;
        cyc();

        // Reset asserted in the middle of the payload
        start_hist();
        feed_base = 0; feed_lim = 46;
        bus.tx_len = 16'd46; bus.tx_start = 1'b1;
        cyc();
        bus.tx_start = 1'b0;
        run(26);
        check("pre-reset s_ready", 32'(bus.s_ready),    32'd1);
        check("pre-reset tx_en",   32'(bus.gmii_tx_en), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("mid reset tx_en",   32'(bus.gmii_tx_en), 32'd0);
        check("mid reset tx_er",   32'(bus.gmii_tx_er), 32'd0);
        check("mid reset busy",    32'(bus.busy),       32'd0);
        check("mid reset s_ready", 32'(bus.s_ready),    32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        feed_lim = 0;
        cyc();
        check("post reset state", 32'(o_state),           32'd0);
        check("post reset tx_en", 32'(bus.gmii_tx_en),    32'd0);

        // Minimum-size payload, no padding
        start_hist();
        feed_base = 0; feed_lim = 46;
        bus.tx_len = 16'd46; bus.tx_start = 1'b1;
        cyc();
        bus.tx_start = 1'b0;
        run(90);
        find_frames();
        check("t2 frame count", 32'(fr_s.size()), 32'd1);
        check("t2 first byte latency", 32'(fr_s.size() > 0 ? fr_s[0] : -1), 32'd1);
        check_frame("t2", 0, 46, 0);
        check("t2 tx_er cycles", 32'(count_q(1, 0, en_h.size() - 1)), 32'd0);
        check("t2 s_ready transfers", 32'(n_fire), 32'd46);

        // Short payload padded to minimum
        start_hist();
        feed_base = 8'h40; feed_lim = 50;
        bus.tx_len = 16'd10; bus.tx_start = 1'b1;
        cyc();
        bus.tx_start = 1'b0;
        run(90);
        find_frames();
        check("t3 frame count", 32'(fr_s.size()), 32'd1);
        check("t3 s_ready transfers", 32'(n_fire), 32'd10);
        check_frame("t3", 0, 10, 8'h40);

        // Maximum length with an underrun at payload byte 100
        start_hist();
        feed_base = 0; feed_lim = 1600; drop_at = 100;
        bus.tx_len = 16'd1500; bus.tx_start = 1'b1;
        cyc();
        bus.tx_start = 1'b0;
        run(140);
        drop_at = 1 << 30;
        er_idx = -1;
        for (int i = 0; i < er_h.size(); i++) if (er_h[i] && er_idx < 0) er_idx = i;
        check("t4 tx_er cycles", 32'(count_q(1, 0, er_h.size() - 1)), 32'd1);
        check("t4 error cycle index", 32'(er_idx), 32'd123);
        check("t4 tx_en cycles", 32'(count_q(0, 0, en_h.size() - 1)), 32'd123);
        check("t4 error data", 32'(getd(er_idx)), 32'd0);
        check("t4 error tx_en", 32'(er_idx >= 0 ? en_h[er_idx] : 1'b0), 32'd1);
        check("t4 gap tx_en", 32'(count_q(0, er_idx + 1, er_idx + 12)), 32'd0);
        check("t4 busy in gap", 32'((er_idx >= 0 && er_idx + 1 < busy_h.size()) ? busy_h[er_idx + 1] : 1'bx), 32'd1);
        check("t4 busy after gap", 32'((er_idx >= 0 && er_idx + 12 < busy_h.size()) ? busy_h[er_idx + 12] : 1'bx), 32'd0);

        // Rejected lengths
        start_hist();
        feed_lim = 0;
        bus.tx_len = 16'd0; bus.tx_start = 1'b1;
        cyc();
        bus.tx_start = 1'b0;
        check("t5 len 0 len_err", 32'(bus.len_err), 32'd1);
        check("t5 len 0 busy",    32'(bus.busy),    32'd0);
        cyc();
        check("t5 len_err one cycle", 32'(bus.len_err), 32'd0);
        bus.tx_len = 16'd1501; bus.tx_start = 1'b1;
        cyc();
        bus.tx_start = 1'b0;
        check("t5 len 1501 len_err", 32'(bus.len_err), 32'd1);
        run(6);
        check("t5 len_err pulses", 32'(count_q(2, 0, lerr_h.size() - 1)), 32'd2);
        check("t5 tx_en cycles",   32'(count_q(0, 0, en_h.size() - 1)), 32'd0);

        // Back-to-back frames with tx_start held high
        start_hist();
        feed_base = 0; feed_lim = 92;
        bus.tx_len = 16'd46; bus.tx_start = 1'b1;
        run(100);
        bus.tx_len = 16'd0;
        run(20);
        bus.tx_start = 1'b0;
        run(60);
        find_frames();
        check("t6 frame count", 32'(fr_s.size()), 32'd2);
        check("t6 inter-frame gap", 32'(fr_s.size() > 1 ? fr_s[1] - fr_e[0] - 1 : -1), 32'd12);
        check("t6 len_err while busy", 32'(count_q(2, 0, lerr_h.size() - 1)), 32'd0);
        check_frame("t6 first", 0, 46, 0);
        check_frame("t6 second", 1, 46, 46);
        nz = 0;
        for (int i = 0; i < er_h.size(); i++) if (er_h[i]) nz++;
        check("t6 tx_er cycles", 32'(nz), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
